// File: rtl/fifo_pkg.sv
// Shared constants for the synchronous FIFO: default widths, thresholds
// and the depth derivation used by the FIFO and its storage.
package fifo_pkg;
    localparam int DEF_DW        = 60;
    localparam int DEF_AW        = 9;
    localparam int DEF_AE_LEVEL  = 4;
    localparam int DEF_AF_MARGIN = 4;

    function automatic int depth_of(input int aw);
        return 1 << aw;
    endfunction
endpackage

// File: rtl/dpram_param.sv
// Simple dual-port RAM: one write port, one registered read port with
// 1-cycle latency. Read of an address being written returns the old word.
module dpram_param #(
    parameter int DW = 8,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/fifo_sync_param.sv
// Single-clock FIFO with count/threshold flags, sticky error flags and an
// optional first-word-fall-through output stage.
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int DW       = DEF_DW,
    parameter int AW       = DEF_AW,
    parameter int FWFT     = 0,
    parameter int AF_LEVEL = depth_of(AW) - DEF_AF_MARGIN,
    parameter int AE_LEVEL = DEF_AE_LEVEL
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic [DW-1:0] din,
    input  logic          we,
    input  logic          re,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          underflow
);
    localparam int          DEPTH   = depth_of(AW);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_C    = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE_C    = (AW+1)'(AE_LEVEL);

    logic [AW-1:0] wptr, rptr, rptr_n, raddr;
    logic [AW:0]   cnt, cnt_n;
    logic          wr_acc, rd_acc, ram_re, bypass, byp_sel;
    logic          ovf, unf;
    logic [DW-1:0] byp_q, ram_q;

    assign full         = (cnt == DEPTH_C);
    assign empty        = (cnt == '0);
    assign almost_full  = (cnt >= AF_C);
    assign almost_empty = (cnt <= AE_C);
    assign count        = cnt;
    assign overflow     = ovf;
    assign underflow    = unf;

    assign wr_acc = we && !full && !clr;
    assign rd_acc = re && !empty && !clr;
    assign rptr_n = rptr + AW'(rd_acc);
    assign cnt_n  = cnt + (AW+1)'(wr_acc) - (AW+1)'(rd_acc);

    // FWFT keeps the head word on dout: the RAM is re-read at the next head
    // every cycle, except when the incoming word becomes the head, which is
    // captured straight from din (the RAM cannot return it in time).
    assign bypass = (FWFT != 0) && wr_acc && (cnt == (AW+1)'(rd_acc));
    assign ram_re = (FWFT != 0) ? (!clr && cnt_n != '0) : rd_acc;
    assign raddr  = (FWFT != 0) ? rptr_n : rptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            ovf  <= 1'b0;
            unf  <= 1'b0;
        end else if (clr) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            ovf  <= 1'b0;
            unf  <= 1'b0;
        end else begin
            wptr <= wptr + AW'(wr_acc);
            rptr <= rptr_n;
            cnt  <= cnt_n;
            if (we && full)  ovf <= 1'b1;
            if (re && empty) unf <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byp_sel <= 1'b0;
            byp_q   <= '0;
        end else if (ram_re) begin
            byp_sel <= bypass;
            if (bypass) byp_q <= din;
        end
    end

    dpram_param #(.DW(DW), .AW(AW)) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc),
        .waddr (wptr),
        .wdata (din),
        .re    (ram_re),
        .raddr (raddr),
        .rdata (ram_q)
    );

    assign dout = byp_sel ? byp_q : ram_q;
endmodule

// File: tb/tb_fifo_sync_param.sv
// Checks standard and FWFT FIFO instances, driven in lockstep, against a
// queue-based reference model.
module tb_fifo_sync_param;
    logic       clk = 1'b0;
    logic       rst, clr, we, re;
    logic [7:0] din;

    logic [7:0] dout0, dout1;
    logic       full0, empty0, af0, ae0, ovf0, unf0;
    logic       full1, empty1, af1, ae1, ovf1, unf1;
    logic [2:0] count0, count1;

    int checks = 0;
    int errors = 0;

    logic [7:0] mq[$];
    logic       m_ovf, m_unf;
    logic [7:0] e0, e1;

    always #5 clk = ~clk;

    fifo_sync_param #(.DW(8), .AW(2), .FWFT(0), .AF_LEVEL(3), .AE_LEVEL(1)) u0 (
        .clk(clk), .rst(rst), .clr(clr), .din(din), .we(we), .re(re),
        .dout(dout0), .full(full0), .empty(empty0), .almost_full(af0),
        .almost_empty(ae0), .count(count0), .overflow(ovf0), .underflow(unf0));

    fifo_sync_param #(.DW(8), .AW(2), .FWFT(1), .AF_LEVEL(3), .AE_LEVEL(1)) u1 (
        .clk(clk), .rst(rst), .clr(clr), .din(din), .we(we), .re(re),
        .dout(dout1), .full(full1), .empty(empty1), .almost_full(af1),
        .almost_empty(ae1), .count(count1), .overflow(ovf1), .underflow(unf1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        e0 = 8'h00;
        e1 = 8'h00;
    endtask

    task automatic model_edge(input logic w, input logic r, input logic [7:0] d, input logic c);
        int n;
        n = mq.size();
        if (c) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (w && n == 4) m_ovf = 1'b1;
            if (r && n == 0) m_unf = 1'b1;
            if (r && n > 0)  e0 = mq.pop_front();
            if (w && n < 4)  mq.push_back(d);
            if (mq.size() > 0) e1 = mq[0];
        end
    endtask

    task automatic check_all();
        int n;
        n = mq.size();
        chk("count0", 32'(count0), 32'(n));
        chk("count1", 32'(count1), 32'(n));
        chk("full0",  32'(full0),  32'(n == 4));
        chk("full1",  32'(full1),  32'(n == 4));
        chk("empty0", 32'(empty0), 32'(n == 0));
        chk("empty1", 32'(empty1), 32'(n == 0));
        chk("af0",    32'(af0),    32'(n >= 3));
        chk("af1",    32'(af1),    32'(n >= 3));
        chk("ae0",    32'(ae0),    32'(n <= 1));
        chk("ae1",    32'(ae1),    32'(n <= 1));
        chk("ovf0",   32'(ovf0),   32'(m_ovf));
        chk("ovf1",   32'(ovf1),   32'(m_ovf));
        chk("unf0",   32'(unf0),   32'(m_unf));
        chk("unf1",   32'(unf1),   32'(m_unf));
        chk("dout0",  32'(dout0),  32'(e0));
        if (n > 0) chk("dout1_head", 32'(dout1), 32'(e1));
    endtask

    // Drive at negedge, model the posedge, check at the following negedge.
    task automatic cyc(input logic w, input logic r, input logic [7:0] d, input logic c);
        we = w; re = r; din = d; clr = c;
        @(posedge clk);
        model_edge(w, r, d, c);
        @(negedge clk);
        check_all();
    endtask

    task automatic async_rst();
        we = 1'b0; re = 1'b0; clr = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_count0", 32'(count0), 32'd0);
        chk("arst_count1", 32'(count1), 32'd0);
        chk("arst_empty0", 32'(empty0), 32'd1);
        chk("arst_empty1", 32'(empty1), 32'd1);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        check_all();
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; we = 1'b0; re = 1'b0; din = 8'h00;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        chk("rst_dout1", 32'(dout1), 32'd0);
        rst = 1'b0;

        // Fill to full, then drain in order.
        cyc(1, 0, 8'h11, 0);
        chk("fwft_first", 32'(dout1), 32'h11);
        cyc(1, 0, 8'h22, 0);
        cyc(1, 0, 8'h33, 0);
        cyc(1, 0, 8'h44, 0);
        chk("full_at4", 32'(full0), 32'd1);
        for (int i = 0; i < 4; i++) cyc(0, 1, 8'h00, 0);
        chk("drain_last", 32'(dout0), 32'h44);

        // Overflow: refused write must never surface; clr drops the flag.
        for (int i = 0; i < 4; i++) cyc(1, 0, 8'h60 + 8'(i), 0);
        cyc(1, 0, 8'h55, 0);
        chk("ovf_set", 32'(ovf0), 32'd1);
        cyc(1, 1, 8'h55, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 8'h00, 0);
        cyc(0, 0, 8'h00, 1);
        chk("clr_ovf", 32'(ovf0), 32'd0);

        // Simultaneous read/write at count=2 across the pointer wrap.
        cyc(1, 0, 8'h71, 0);
        cyc(1, 0, 8'h72, 0);
        for (int i = 0; i < 6; i++) cyc(1, 1, 8'h80 + 8'(i), 0);
        chk("rw_count", 32'(count0), 32'd2);
        cyc(0, 0, 8'h00, 1);

        // FWFT head appears with no read.
        cyc(1, 0, 8'hA5, 0);
        chk("fwft_a5", 32'(dout1), 32'hA5);
        cyc(0, 0, 8'h00, 0);
        cyc(0, 1, 8'h00, 0);

        // Underflow on empty, then async reset with words held.
        cyc(0, 1, 8'h00, 0);
        chk("unf_set", 32'(unf0), 32'd1);
        cyc(1, 0, 8'hC1, 0);
        cyc(1, 0, 8'hC2, 0);
        cyc(1, 0, 8'hC3, 0);
        async_rst();
        cyc(1, 0, 8'h9C, 0);
        cyc(1, 0, 8'h9D, 0);
        cyc(0, 1, 8'h00, 0);
        chk("post_rst_first", 32'(dout0), 32'h9C);

        // Random traffic with occasional clears.
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 50),
                8'($urandom), 1'($urandom_range(0, 39) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/fifo_sync_param.md
FIFO_SYNC_PARAM -- requirements
Module: fifo_sync_param

Interface
REQ-001 SHALL have parameter DW, default 60, data width in bits.
REQ-002 SHALL have parameter AW, default 9, address width; DEPTH = 2^AW words.
REQ-003 SHALL have parameter FWFT, default 0; 0 = standard read, 1 = first-word-fall-through.
REQ-004 SHALL have parameter AF_LEVEL, default DEPTH-4; almost_full threshold.
REQ-005 SHALL have parameter AE_LEVEL, default 4; almost_empty threshold.
REQ-006 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port clr  input  1  synchronous clear of pointers, count and flags.
REQ-009 SHALL have port din  input  DW  write data.
REQ-010 SHALL have port we  input  1  write request.
REQ-011 SHALL have port re  input  1  read request (pop).
REQ-012 SHALL have port dout  output  DW  read data.
REQ-013 SHALL have ports full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-014 SHALL have port count  output  AW+1  words held, range 0..DEPTH.
REQ-015 SHALL have ports overflow, underflow  output  1 each  sticky error flags.

Function
REQ-016 SHALL accept a write iff we=1 and full=0; a refused write leaves storage, pointers and count unchanged.
REQ-017 SHALL accept a read iff re=1 and empty=0; a refused read leaves pointers, count and dout unchanged.
REQ-018 SHALL wrap write and read pointers modulo DEPTH with no gap.
REQ-019 SHALL update count by +1 on accepted write only, -1 on accepted read only, unchanged when both or neither.
REQ-020 SHALL drive full = (count==DEPTH), empty = (count==0), almost_full = (count>=AF_LEVEL), almost_empty = (count<=AE_LEVEL), all from registered count.
REQ-021 When full, we=1 and re=1: SHALL accept the read only; when empty, we=1 and re=1: SHALL accept the write only.
REQ-022 FWFT=0: dout SHALL update one cycle after an accepted read with the word at the read pointer, holding its value otherwise.
REQ-023 FWFT=1: head word SHALL be present on dout whenever empty=0; an accepted read SHALL present the next word on the following cycle if available.
REQ-024 FWFT=1: count SHALL include the word staged on dout; empty SHALL deassert no later than 2 cycles after the first write into an empty FIFO.
REQ-025 FWFT=0: empty SHALL deassert 1 cycle after the first accepted write; full SHALL assert 1 cycle after the DEPTH-th accepted write.
REQ-026 overflow SHALL set on any cycle with we=1 and full=1; underflow SHALL set on any cycle with re=1 and empty=1; both hold until clr or rst.
REQ-027 clr SHALL take priority over we/re in the same cycle, zeroing pointers, count, overflow, underflow; stored data is not cleared.

Reset
REQ-028 rst SHALL asynchronously force pointers=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0 (AF_LEVEL>0), overflow=0, underflow=0, dout=0.
REQ-029 rst asserted mid-operation SHALL discard all held words; first read after release returns the first word written after release.

Structure
REQ-030 SHALL keep DEPTH derivation and default DW/AW/threshold constants in a shared package fifo_pkg.
REQ-031 SHALL instantiate one sub-module dpram_param (one read port, one write port, registered read, 1-cycle latency) as storage.

Verification (DW=8, AW=2, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1)
REQ-032 FWFT=0: write 0x11,0x22,0x33,0x44 -> full=1, count=4; read 4 -> dout 0x11..0x44 in order, empty=1.
REQ-033 Full, we=1 din=0x55 -> overflow=1, count=4, later reads never return 0x55; clr -> overflow=0, count=0.
REQ-034 Count=2, we=1 re=1 for 6 cycles across pointer wrap -> count stays 2, data order preserved.
REQ-035 FWFT=1: write 0xA5 to empty FIFO -> dout=0xA5 with empty=0 within 2 cycles, no re needed.
REQ-036 Empty, re=1 -> underflow=1, dout unchanged; rst asserted with count=3 -> count=0, empty=1 same cycle.
